// File: rtl/des_host_pkg.sv
// Shared types and sizes for the DES host front end.
package des_host_pkg;
  localparam int unsigned BLOCK_BYTES = 8;
  localparam int unsigned BLOCK_W     = 64;

  typedef enum logic {IN_FILL,   IN_FULL}   in_state_e;
  typedef enum logic {CORE_IDLE, CORE_WAIT} core_state_e;
  typedef enum logic {OUT_EMPTY, OUT_DRAIN} out_state_e;
endpackage

// File: rtl/des_block_host_if.sv
// Byte-stream and DES-core signal bundle for des_block_host.
interface des_block_host_if;
  import des_host_pkg::*;

  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_mode;
  logic               in_ready;
  logic [7:0]         out_byte;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] core_data_in;
  logic               core_ready;
  logic               core_ed_sel;
  logic [BLOCK_W-1:0] core_data_out;
  logic               core_next_data;
  logic               busy;
  logic               err;

  modport slave (
    input  in_byte, in_valid, in_mode, out_ready, core_data_out, core_next_data,
    output in_ready, out_byte, out_valid, core_data_in, core_ready, core_ed_sel, busy, err
  );

  modport master (
    output in_byte, in_valid, in_mode, out_ready, core_data_out, core_next_data,
    input  in_ready, out_byte, out_valid, core_data_in, core_ready, core_ed_sel, busy, err
  );
endinterface

// File: rtl/des_byte_shreg.sv
// 64-bit byte-wise shift register: parallel load, shift-left-by-byte, byte count with wrap flag.
module des_byte_shreg
  import des_host_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [7:0]         din,
  output logic [BLOCK_W-1:0] data,
  output logic [2:0]         count,
  output logic               wrap
);
  assign wrap = shift && (count == 3'(BLOCK_BYTES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift) begin
      data  <= {data[BLOCK_W-9:0], din};
      count <= count + 3'd1;
    end
  end
endmodule

// File: rtl/des_block_host.sv
// Host front end for the DES core: byte assembly, block issue/wait, byte serialization.
// Optional core watchdog enabled by defining DES_HOST_TIMEOUT_EN.
module des_block_host
  import des_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             n_rst,
  des_block_host_if.slave bus
);
  in_state_e          in_st;
  core_state_e        core_st;
  out_state_e         out_st;
  logic [BLOCK_W-1:0] in_data, out_data, core_data_q;
  logic [2:0]         in_cnt, out_cnt;
  logic               in_wrap, out_wrap;
  logic               mode_buf, core_ready_q, core_ed_sel_q, busy_q;
  logic               in_accept, issue, done, out_xfer, expire;
  logic               unused_bits;

  assign in_accept = (in_st == IN_FILL) && bus.in_valid;
  assign out_xfer  = (out_st == OUT_DRAIN) && bus.out_ready;
  assign done      = (core_st == CORE_WAIT) && bus.core_next_data;
  // out_st is registered, so a block waiting on the final drain byte issues one cycle later
  assign issue     = (in_st == IN_FULL) && (core_st == CORE_IDLE) && (out_st == OUT_EMPTY);

  des_byte_shreg u_in_asm (
    .clk(clk), .n_rst(n_rst), .load(1'b0), .load_data('0), .shift(in_accept),
    .din(bus.in_byte), .data(in_data), .count(in_cnt), .wrap(in_wrap)
  );

  des_byte_shreg u_out_ser (
    .clk(clk), .n_rst(n_rst), .load(done), .load_data(bus.core_data_out), .shift(out_xfer),
    .din(8'h00), .data(out_data), .count(out_cnt), .wrap(out_wrap)
  );

`ifdef DES_HOST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            err_q;

  assign expire = (core_st == CORE_WAIT) && !bus.core_next_data &&
                  (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else if (issue || done || expire) begin
      wd    <= '0;
      err_q <= err_q | expire;
    end else if (core_st == CORE_WAIT) begin
      wd <= wd + 1'b1;
    end
  end

  assign bus.err     = err_q;
  assign unused_bits = ^{out_data[BLOCK_W-9:0], out_cnt};
`else
  assign expire      = 1'b0;
  assign bus.err     = 1'b0;
  assign unused_bits = ^{out_data[BLOCK_W-9:0], out_cnt, TIMEOUT_CYCLES[0]};
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_st         <= IN_FILL;
      core_st       <= CORE_IDLE;
      out_st        <= OUT_EMPTY;
      mode_buf      <= 1'b0;
      core_data_q   <= '0;
      core_ready_q  <= 1'b0;
      core_ed_sel_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      core_ready_q <= 1'b0;
      if (in_accept && (in_cnt == '0)) mode_buf <= bus.in_mode;

      if (in_accept && in_wrap) in_st <= IN_FULL;
      else if (issue)           in_st <= IN_FILL;

      if (issue) begin
        core_data_q   <= in_data;
        core_ed_sel_q <= mode_buf;
        core_ready_q  <= 1'b1;
        core_st       <= CORE_WAIT;
        busy_q        <= 1'b1;
      end else if (done) begin
        core_st <= CORE_IDLE;
        busy_q  <= 1'b0;
        out_st  <= OUT_DRAIN;
      end else if (expire) begin
        core_st <= CORE_IDLE;
        busy_q  <= 1'b0;
      end

      if (out_xfer && out_wrap) out_st <= OUT_EMPTY;
    end
  end

  assign bus.in_ready     = (in_st == IN_FILL);
  assign bus.out_valid    = (out_st == OUT_DRAIN);
  assign bus.out_byte     = out_data[BLOCK_W-1 -: 8];
  assign bus.core_data_in = core_data_q;
  assign bus.core_ready   = core_ready_q;
  assign bus.core_ed_sel  = core_ed_sel_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_des_block_host.sv
// Self-checking bench for des_block_host with a behavioural DES-core stub and byte-stream model.
module tb_des_block_host;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  des_block_host_if bus ();

  des_block_host #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // core stub and issue monitor
  logic        stub_en = 1'b1;
  int          stub_lat = 17;
  logic        stray_req = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_resp = '0;
  logic        prev_ready = 1'b0;
  int          multi_pulse = 0;
  int          done_edge = -1;
  logic [63:0] resp_q[$];
  logic [63:0] issue_data[$];
  logic        issue_mode[$];
  int          issue_edge[$];
  logic [7:0]  got_q[$];
  int          got_edge[$];
  logic [7:0]  held_q[$];
  int          hold_viol = 0;

  always @(negedge clk) begin
    if (bus.core_next_data) bus.core_next_data = 1'b0;
    if (stray_req) begin
      bus.core_next_data = 1'b1;
      bus.core_data_out  = {$urandom, $urandom};
      stray_req          = 1'b0;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        bus.core_next_data = 1'b1;
        bus.core_data_out  = pend_resp;
        done_edge          = cyc + 1;
        pend               = 1'b0;
      end else pend_cnt--;
    end
    if (bus.core_ready) begin
      issue_data.push_back(bus.core_data_in);
      issue_mode.push_back(bus.core_ed_sel);
      issue_edge.push_back(cyc);
      if (prev_ready) multi_pulse++;
      if (stub_en) begin
        pend      = 1'b1;
        pend_cnt  = (stub_lat > 0 ? stub_lat : $urandom_range(1, 30)) - 1;
        pend_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 64'h0;
      end
    end
    prev_ready = bus.core_ready;
  end

  task automatic clear_logs();
    issue_data.delete(); issue_mode.delete(); issue_edge.delete();
    got_q.delete(); got_edge.delete(); held_q.delete();
    resp_q.delete();
    hold_viol = 0; multi_pulse = 0;
  endtask

  task automatic send_block(input logic [63:0] d, input logic m, input bit bubbles, output int last);
    int i = 0, g = 0;
    logic r;
    logic [63:0] dv = d;
    last = -1;
    @(negedge clk);
    while (i < 8 && g < 500) begin
      r = bus.in_ready;
      if (bubbles && r && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        r = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = r ? dv[63-8*i -: 8] : 8'($urandom);
        bus.in_mode  = (r && i == 0) ? m : 1'($urandom);
      end
      if (r) last = cyc + 1;
      @(negedge clk);
      if (r) i++;
      g++;
    end
    bus.in_valid = 1'b0;
    if (i < 8) begin
      checks++; errors++;
      $display("FAIL send_timeout sent %0d bytes, required 8", i);
    end
  endtask

  task automatic recv(input int n, input int pat, output int first_cyc);
    int got = 0, k = 0, g = 0;
    logic v, rdy, held = 1'b0;
    logic [7:0] b, hb = '0;
    logic [3:0] p = 4'b1001;
    first_cyc = -1;
    while (got < n && g < 3000) begin
      @(negedge clk);
      v = bus.out_valid;
      b = bus.out_byte;
      if (v && held && b !== hb) hold_viol++;
      if (v && first_cyc < 0) first_cyc = cyc;
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = (k < 4) ? p[3-k] : 1'b1;
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      bus.out_ready = rdy;
      if (v) begin
        if (rdy) begin
          got_q.push_back(b); got_edge.push_back(cyc + 1); got++; held = 1'b0;
        end else begin
          held = 1'b1; hb = b; held_q.push_back(b);
        end
        k++;
      end
      g++;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL recv_timeout got %0d bytes, required %0d", got, n);
    end
  endtask

  task automatic wait_idle_window(input int n, output int seen_valid);
    seen_valid = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00) begin errors++; $display("FAIL rst_out got %b/%h exp 0/00", bus.out_valid, bus.out_byte); end
    checks++; if (bus.core_data_in !== 64'h0 || bus.core_ready !== 1'b0 || bus.core_ed_sel !== 1'b0) begin errors++; $display("FAIL rst_core got %h/%b/%b exp 0", bus.core_data_in, bus.core_ready, bus.core_ed_sel); end
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_busy_err got %b/%b exp 0/0", bus.busy, bus.err); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int last, first;
    logic [63:0] resp = 64'h85E813540F0AB405;
    clear_logs(); stub_lat = 17; stub_en = 1'b1;
    resp_q.push_back(resp);
    send_block(64'h0102030405060708, 1'b0, 1'b0, last);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_full got in_ready %b exp 0", bus.in_ready); end
    recv(8, 0, first);
    checks++; if (issue_data.size() != 1 || issue_data[0] !== 64'h0102030405060708 || issue_mode[0] !== 1'b0)
      begin errors++; $display("FAIL basic_issue got n=%0d data %h exp 1 block 0102030405060708 mode 0", issue_data.size(), issue_data.size() ? issue_data[0] : 64'h0); end
    checks++; if (issue_edge.size() == 0 || issue_edge[0] != last + 1) begin errors++; $display("FAIL basic_issue_lat got edge %0d exp %0d", issue_edge.size() ? issue_edge[0] : -1, last + 1); end
    checks++; if (multi_pulse != 0) begin errors++; $display("FAIL basic_ready_pulse got %0d extra cycles exp 0", multi_pulse); end
    checks++; if (first != done_edge) begin errors++; $display("FAIL basic_out_lat got %0d exp %0d", first, done_edge); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== resp[63-8*i -: 8]) begin
        errors++; $display("FAIL basic_out_byte%0d got %h exp %h", i, i < got_q.size() ? got_q[i] : 8'hxx, resp[63-8*i -: 8]);
      end
    end
  endtask

  task automatic test_backpressure();
    int last, first;
    logic [63:0] resp = 64'h85E813540F0AB405;
    clear_logs(); stub_lat = 5;
    resp_q.push_back(resp);
    send_block({$urandom, $urandom}, 1'b0, 1'b1, last);
    recv(8, 1, first);
    checks++; if (held_q.size() != 2 || held_q[0] !== 8'hE8 || held_q[1] !== 8'hE8) begin errors++; $display("FAIL bp_hold got %0d held bytes first %h exp 2 x E8", held_q.size(), held_q.size() ? held_q[0] : 8'h00); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", hold_viol); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== resp[63-8*i -: 8]) begin
        errors++; $display("FAIL bp_byte%0d got %h exp %h", i, i < got_q.size() ? got_q[i] : 8'hxx, resp[63-8*i -: 8]);
      end
    end
  endtask

  task automatic test_overlap();
    int l1, l2, first;
    logic r2 = 1'b1;
    logic [63:0] resp1 = {$urandom, $urandom}, resp2 = {$urandom, $urandom};
    logic [63:0] exp_out;
    clear_logs(); stub_lat = 20;
    resp_q.push_back(resp1); resp_q.push_back(resp2);
    fork
      begin
        send_block({$urandom, $urandom}, 1'b0, 1'b0, l1);
        send_block(64'hAAABACADAEAFB0B1, 1'b1, 1'b0, l2);
        r2 = bus.in_ready;
      end
      recv(16, 2, first);
    join
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL ovl_full got in_ready %b exp 0", r2); end
    checks++; if (issue_data.size() != 2 || issue_data[1] !== 64'hAAABACADAEAFB0B1 || issue_mode[1] !== 1'b1)
      begin errors++; $display("FAIL ovl_issue2 got n=%0d data %h mode %b exp AAABACADAEAFB0B1 mode 1", issue_data.size(), issue_data.size() > 1 ? issue_data[1] : 64'h0, issue_mode.size() > 1 ? issue_mode[1] : 1'bx); end
    checks++; if (issue_edge.size() < 2 || got_edge.size() < 8 || issue_edge[1] != got_edge[7] + 1)
      begin errors++; $display("FAIL ovl_issue2_edge got %0d exp %0d", issue_edge.size() > 1 ? issue_edge[1] : -1, got_edge.size() > 7 ? got_edge[7] + 1 : -1); end
    for (int i = 0; i < 16; i++) begin
      exp_out = (i < 8) ? resp1 : resp2;
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_out[63-8*(i%8) -: 8]) begin
        errors++; $display("FAIL ovl_byte%0d got %h exp %h", i, i < got_q.size() ? got_q[i] : 8'hxx, exp_out[63-8*(i%8) -: 8]);
      end
    end
  endtask

  task automatic test_stray();
    int seen;
    clear_logs();
    stray_req = 1'b1;
    wait_idle_window(10, seen);
    checks++; if (seen != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stray got valid cycles %0d busy %b exp 0/0", seen, bus.busy); end
  endtask

  task automatic test_reset_wait();
    int last, g = 0, seen;
    clear_logs(); stub_lat = 10;
    resp_q.push_back({$urandom, $urandom});
    send_block({$urandom, $urandom}, 1'b1, 1'b0, last);
    while (!bus.core_ready && g < 50) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rw_busy got %b exp 1", bus.busy); end
    n_rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.core_data_in !== 64'h0 || bus.core_ed_sel !== 1'b0 || bus.core_ready !== 1'b0)
      begin errors++; $display("FAIL rw_async got busy %b data %h ed %b exp 0", bus.busy, bus.core_data_in, bus.core_ed_sel); end
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00) begin errors++; $display("FAIL rw_async_io got %b/%b/%h exp 1/0/00", bus.in_ready, bus.out_valid, bus.out_byte); end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    wait_idle_window(20, seen);
    checks++; if (seen != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rw_late got valid cycles %0d busy %b exp 0/0", seen, bus.busy); end
  endtask

  task automatic test_random();
    int last, first;
    logic [63:0] blk[4], rsp[4];
    logic        md[4];
    clear_logs(); stub_lat = 0;
    for (int b = 0; b < 4; b++) begin
      blk[b] = {$urandom, $urandom}; rsp[b] = {$urandom, $urandom}; md[b] = 1'($urandom);
      resp_q.push_back(rsp[b]);
    end
    fork
      for (int b = 0; b < 4; b++) send_block(blk[b], md[b], 1'b1, last);
      recv(32, 2, first);
    join
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (b >= issue_data.size() || issue_data[b] !== blk[b] || issue_mode[b] !== md[b]) begin
        errors++; $display("FAIL rnd_issue%0d got %h/%b exp %h/%b", b, b < issue_data.size() ? issue_data[b] : 64'h0, b < issue_mode.size() ? issue_mode[b] : 1'bx, blk[b], md[b]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== rsp[i/8][63-8*(i%8) -: 8]) begin
        errors++; $display("FAIL rnd_byte%0d got %h exp %h", i, i < got_q.size() ? got_q[i] : 8'hxx, rsp[i/8][63-8*(i%8) -: 8]);
      end
    end
    checks++; if (hold_viol != 0 || multi_pulse != 0) begin errors++; $display("FAIL rnd_protocol got hold %0d pulse %0d exp 0/0", hold_viol, multi_pulse); end
  endtask

`ifdef DES_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int last, g = 0, busy_cycles = 0, seen, first;
    logic [63:0] resp = {$urandom, $urandom};
    clear_logs(); stub_en = 1'b0;
    send_block({$urandom, $urandom}, 1'b0, 1'b0, last);
    while (!bus.core_ready && g < 50) begin @(negedge clk); g++; end
    while (bus.busy && busy_cycles < 300) begin busy_cycles++; @(negedge clk); end
    checks++; if (busy_cycles != 64) begin errors++; $display("FAIL to_cycles got %0d exp 64", busy_cycles); end
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL to_err got err %b busy %b exp 1/0", bus.err, bus.busy); end
    wait_idle_window(10, seen);
    checks++; if (seen != 0) begin errors++; $display("FAIL to_no_out got %0d valid cycles exp 0", seen); end
    stub_en = 1'b1; stub_lat = 8;
    resp_q.push_back(resp);
    send_block(64'h1122334455667788, 1'b1, 1'b0, last);
    recv(8, 0, first);
    checks++; if (issue_data.size() != 2 || issue_data[1] !== 64'h1122334455667788) begin errors++; $display("FAIL to_reissue got n=%0d exp 2", issue_data.size()); end
    checks++; if (got_q.size() != 8 || got_q[0] !== resp[63:56] || got_q[7] !== resp[7:0]) begin errors++; $display("FAIL to_out got %0d bytes exp 8 of %h", got_q.size(), resp); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", bus.err); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_byte = '0; bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.out_ready = 1'b1;
    bus.core_data_out = '0; bus.core_next_data = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overlap();
    test_stray();
    test_reset_wait();
    test_random();
`ifdef DES_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
